// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: an input capture register followed by one log-stage per amount bit.
// Supports SLL/ROL/SRL/SRA/ROR plus pass-through, with a valid/ready handshake on both sides.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SAW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_ROL = 3'd1;
    localparam logic [2:0] MODE_SRL = 3'd2;
    localparam logic [2:0] MODE_SRA = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    // Index 0 is the input capture register; index k (1..SAW) holds the result of shift stage k-1.
    localparam int NREG = SAW + 1;

    logic [WIDTH-1:0] data_q  [NREG];
    logic [WIDTH-1:0] data_d  [NREG];
    logic             valid_q [NREG];
    logic             valid_d [NREG];
    logic [SAW-1:0]   amt_q   [SAW];
    logic [SAW-1:0]   amt_d   [SAW];
    logic [2:0]       mode_q  [SAW];
    logic [2:0]       mode_d  [SAW];
    logic             sign_q  [SAW];
    logic             sign_d  [SAW];
    logic             zero_q;
    logic             zero_d;
    logic             stall;

    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
        case (mode)
            MODE_SLL: shift_pow2 = d << sh;
            MODE_ROL: shift_pow2 = (d << sh) | (d >> (WIDTH - sh));
            MODE_SRL: shift_pow2 = d >> sh;
            MODE_SRA: shift_pow2 = (d >> sh) | fill;
            MODE_ROR: shift_pow2 = (d >> sh) | (d << (WIDTH - sh));
            default:  shift_pow2 = d;
        endcase
    endfunction

    assign stall     = valid_q[SAW] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = valid_q[SAW];
    assign out_data  = data_q[SAW];
    assign out_zero  = zero_q;

    always_comb begin
        data_d[0]  = in_data;
        valid_d[0] = in_valid;
        amt_d[0]   = in_amt;
        mode_d[0]  = in_mode;
        // The sign is taken from the original operand so SRA fill never depends on partial results.
        sign_d[0]  = in_data[WIDTH-1];
        for (int k = 1; k < NREG; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = amt_q[k-1][k-1]
                       ? shift_pow2(data_q[k-1], mode_q[k-1], sign_q[k-1], 1 << (k - 1))
                       : data_q[k-1];
        end
        for (int k = 1; k < SAW; k++) begin
            amt_d[k]  = amt_q[k-1];
            mode_d[k] = mode_q[k-1];
            sign_d[k] = sign_q[k-1];
        end
        zero_d = (data_d[SAW] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                data_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
            for (int k = 0; k < SAW; k++) begin
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                sign_q[k] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NREG; k++) begin
                data_q[k]  <= data_d[k];
                valid_q[k] <= valid_d[k];
            end
            for (int k = 0; k < SAW; k++) begin
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
                sign_q[k] <= sign_d[k];
            end
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and randomized bench for shifter_pipe at WIDTH=32 (main), 8 and 64.
module tb_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_amt;
    logic [2:0]  a_in_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_amt;
    logic [2:0]  b_in_mode;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero;
    logic [63:0] c_in_data, c_out_data;
    logic [5:0]  c_in_amt;
    logic [2:0]  c_in_mode;

    shifter_pipe #(.WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_amt(a_in_amt), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_zero(a_out_zero)
    );
    shifter_pipe #(.WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_amt(b_in_amt), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_zero(b_out_zero)
    );
    shifter_pipe #(.WIDTH(64)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_amt(c_in_amt), .in_mode(c_in_mode),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_zero(c_out_zero)
    );

    // Bit-by-bit reference: each result bit is picked directly from its source bit.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                              input logic [2:0] m, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'd0:    r[i] = (i >= a) ? d[i-a] : 1'b0;
                3'd1:    r[i] = d[(i - a + w) % w];
                3'd2:    r[i] = (i + a < w) ? d[i+a] : 1'b0;
                3'd3:    r[i] = (i + a < w) ? d[i+a] : d[w-1];
                3'd4:    r[i] = d[(i + a) % w];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    // Issues one op on the 32-bit DUT into an idle pipe and reports result and latency (no checking).
    task automatic op32(input logic [31:0] d, input logic [4:0] amt, input logic [2:0] mode,
                        output logic [31:0] got, output logic gz, output int lat);
        a_in_data = d; a_in_amt = amt; a_in_mode = mode; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0; got = 'x; gz = 1'bx;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (a_out_valid) begin
                got = a_out_data; gz = a_out_zero;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
        checks++; if (a_out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b exp 0", a_out_zero); end
        checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid_w8_w64 got %b %b exp 0 0", b_out_valid, c_out_valid); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    endtask

    task automatic test_shifts();
        logic [31:0] td [7];
        logic [4:0]  ta [7];
        logic [2:0]  tm [7];
        logic [31:0] te [7];
        logic [31:0] got;
        logic gz;
        int lat;
        td = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h0000_0001};
        ta = '{5'd1,          5'd31,         5'd4,          5'd0,          5'd31,         5'd31,         5'd1};
        tm = '{3'd0,          3'd2,          3'd3,          3'd3,          3'd0,          3'd3,          3'd2};
        te = '{32'h0000_0002, 32'h0000_0001, 32'hF800_0000, 32'h8000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            op32(td[i], ta[i], tm[i], got, gz, lat);
            checks++; if (got !== te[i]) begin errors++; $display("FAIL shift_data[%0d] got %h exp %h", i, got, te[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL shift_latency[%0d] got %0d exp 5", i, lat); end
            checks++; if (gz !== (te[i] == 32'd0)) begin errors++; $display("FAIL shift_zero[%0d] got %b exp %b", i, gz, te[i] == 32'd0); end
        end
    endtask

    task automatic test_rotates_pass();
        logic [31:0] td [5];
        logic [4:0]  ta [5];
        logic [2:0]  tm [5];
        logic [31:0] te [5];
        logic [31:0] got;
        logic gz;
        int lat;
        td = '{32'h8000_0001, 32'h0000_000F, 32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF};
        ta = '{5'd4,          5'd4,          5'd7,          5'd31,         5'd0};
        tm = '{3'd1,          3'd4,          3'd6,          3'd4,          3'd1};
        te = '{32'h0000_0018, 32'hF000_0000, 32'h1234_5678, 32'h0000_0003, 32'hDEAD_BEEF};
        for (int i = 0; i < 5; i++) begin
            op32(td[i], ta[i], tm[i], got, gz, lat);
            checks++; if (got !== te[i]) begin errors++; $display("FAIL rot_data[%0d] got %h exp %h", i, got, te[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL rot_latency[%0d] got %0d exp 5", i, lat); end
        end
    endtask

    task automatic test_w8();
        int lat;
        logic [7:0] got;
        b_in_data = 8'h81; b_in_amt = 3'd1; b_in_mode = 3'd4; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0; got = 'x;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (b_out_valid) begin got = b_out_data; break; end
        end
        @(posedge clk); #1;
        checks++; if (got !== 8'hC0) begin errors++; $display("FAIL w8_ror_data got %h exp c0", got); end
        checks++; if (lat != 3) begin errors++; $display("FAIL w8_ror_latency got %0d exp 3", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [8];
        int at [8];
        int n;
        n = 0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) begin
                a_in_valid = 1'b1; a_in_data = 32'd1; a_in_amt = cyc[4:0]; a_in_mode = 3'd0;
            end else a_in_valid = 1'b0;
            @(posedge clk); #1;
            if (a_out_valid && n < 8) begin got[n] = a_out_data; at[n] = cyc; n++; end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== (32'd1 << i)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got[i], 32'd1 << i); end
            checks++; if (at[i] != i + 5) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, at[i], i + 5); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q [$];
        logic [31:0] held, exp, d;
        logic [63:0] r;
        int issued, recv, sim;
        logic held_ok;
        issued = 0; recv = 0; sim = 0; held = '0; held_ok = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a_out_ready = !(cyc >= 7 && cyc <= 9);
            d = 32'hA5A5_0000 | issued;
            a_in_valid = (issued < 12);
            a_in_data = d; a_in_amt = 5'(issued + 1); a_in_mode = 3'(issued % 5);
            #1;
            if (!a_out_ready && a_out_valid) begin
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", cyc, a_in_ready); end
                if (!held_ok) begin held = a_out_data; held_ok = 1'b1; end
                else begin
                    checks++; if (a_out_data !== held) begin errors++; $display("FAIL bp_hold cyc %0d got %h exp %h", cyc, a_out_data, held); end
                end
            end
            if (a_out_valid && a_out_ready) begin
                if (a_in_valid && a_in_ready) sim++;
                exp = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
                checks++; if (a_out_data !== exp) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", recv, a_out_data, exp); end
                recv++;
            end
            if (a_in_valid && a_in_ready) begin
                r = ref_shift({32'd0, d}, issued + 1, 3'(issued % 5), 32);
                q.push_back(r[31:0]);
                issued++;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        checks++; if (recv != 12) begin errors++; $display("FAIL bp_count got %0d exp 12", recv); end
        checks++; if (sim == 0) begin errors++; $display("FAIL bp_simultaneous got %0d exp >0", sim); end
        checks++; if (!held_ok) begin errors++; $display("FAIL bp_stall_seen got 0 exp 1"); end
    endtask

    task automatic test_reset_midflight();
        int n, stale, lat;
        logic [31:0] got;
        logic gz;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'd1; a_in_amt = 5'(i); a_in_mode = 3'd0;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", a_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", a_out_valid); end
        checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", a_out_data); end
        #3 rst_n = 1'b1;
        a_out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale got %0d exp 0", stale); end
        op32(32'h0000_00F0, 5'd4, 3'd2, got, gz, lat);
        checks++; if (got !== 32'h0000_000F) begin errors++; $display("FAIL rst_next_data got %h exp 0000000f", got); end
        checks++; if (lat != 5) begin errors++; $display("FAIL rst_next_latency got %0d exp 5", lat); end
    endtask

    task automatic set_in(input int d, input logic v, input logic [63:0] data, input int amt,
                          input logic [2:0] mode, input logic ordy);
        case (d)
            0: begin a_in_valid = v; a_in_data = data[31:0]; a_in_amt = amt[4:0]; a_in_mode = mode; a_out_ready = ordy; end
            1: begin b_in_valid = v; b_in_data = data[7:0];  b_in_amt = amt[2:0]; b_in_mode = mode; b_out_ready = ordy; end
            default: begin c_in_valid = v; c_in_data = data; c_in_amt = amt[5:0]; c_in_mode = mode; c_out_ready = ordy; end
        endcase
    endtask

    task automatic get_st(input int d, output logic ir, output logic ov, output logic oz, output logic [63:0] od);
        case (d)
            0: begin ir = a_in_ready; ov = a_out_valid; oz = a_out_zero; od = {32'd0, a_out_data}; end
            1: begin ir = b_in_ready; ov = b_out_valid; oz = b_out_zero; od = {56'd0, b_out_data}; end
            default: begin ir = c_in_ready; ov = c_out_valid; oz = c_out_zero; od = c_out_data; end
        endcase
    endtask

    task automatic test_random();
        logic [63:0] q0 [$];
        logic [63:0] q1 [$];
        logic [63:0] q2 [$];
        int w [3];
        int issued [3];
        int recv [3];
        logic [63:0] pd [3];
        int pa [3];
        logic [2:0] pm [3];
        logic v [3];
        logic ordy [3];
        logic ir, ov, oz;
        logic [63:0] od, exp, mask;
        int qs;
        w = '{32, 8, 64};
        for (int d = 0; d < 3; d++) begin
            issued[d] = 0; recv[d] = 0;
            mask = (w[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w[d]) - 64'd1);
            pd[d] = {$urandom, $urandom} & mask; pa[d] = $urandom_range(0, w[d] - 1); pm[d] = 3'($urandom_range(0, 7));
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                ordy[d] = ($urandom_range(0, 3) != 0);
                v[d] = (issued[d] < 40);
                set_in(d, v[d], pd[d], pa[d], pm[d], ordy[d]);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                get_st(d, ir, ov, oz, od);
                if (ov && ordy[d]) begin
                    qs = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
                    if (qs == 0) exp = 'x;
                    else if (d == 0) exp = q0.pop_front();
                    else if (d == 1) exp = q1.pop_front();
                    else exp = q2.pop_front();
                    checks++; if (od !== exp) begin errors++; $display("FAIL rand_w%0d[%0d] got %h exp %h", w[d], recv[d], od, exp); end
                    checks++; if (oz !== (od == 64'd0)) begin errors++; $display("FAIL rand_zero_w%0d[%0d] got %b exp %b", w[d], recv[d], oz, od == 64'd0); end
                    recv[d]++;
                end
                if (v[d] && ir) begin
                    exp = ref_shift(pd[d], pa[d], pm[d], w[d]);
                    if (d == 0) q0.push_back(exp); else if (d == 1) q1.push_back(exp); else q2.push_back(exp);
                    issued[d]++;
                    mask = (w[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w[d]) - 64'd1);
                    pd[d] = {$urandom, $urandom} & mask; pa[d] = $urandom_range(0, w[d] - 1); pm[d] = 3'($urandom_range(0, 7));
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 64'd0, 0, 3'd0, 1'b1);
            checks++; if (recv[d] != 40) begin errors++; $display("FAIL rand_count_w%0d got %0d exp 40", w[d], recv[d]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_amt = '0; c_in_mode = '0; c_out_ready = 1'b1;
        #23;
        test_reset();
        test_shifts();
        test_rotates_pass();
        test_w8();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the combinational 32-bit shifter.
- Mode is selected at run time. Supports logical/arithmetic shifts and true left/right rotates.
- One log-stage per pipeline register, with a valid/ready handshake on input and output.
- Sits between the ALU operand muxes and writeback in the multi-cycle/pipelined CPU datapath.

Parameters:
- WIDTH, 32, data width in bits; power of 2, 8..64.
- SAW, $clog2(WIDTH), shift-amount width and number of pipeline stages.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SAW  shift amount; unsigned; only the low SAW bits exist.
- in_mode  in  3  0=SLL, 1=ROL, 2=SRL, 3=SRA, 4=ROR, 5..7=pass-through.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, out_valid, out_data and out_zero clear to 0.
  - in_ready = 1 once reset is released.
  - Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Handshake:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - Inputs are sampled only on transfer. out_data and out_zero are held stable while out_valid & ~out_ready.
- Stall:
  - Global stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, no stage register updates. Bubbles are not compressed.
- Pipeline: SAW stages.
  - Stage k (k=0..SAW-1) applies a shift of 2^k when amount bit k is 1; otherwise the word passes unchanged.
  - Each stage registers data, amount, mode and valid. The final stage drives out_*.
- Latency: exactly SAW cycles from input transfer to out_valid when not stalled (32-bit: 5 cycles).
- Throughput: 1 op/cycle with no stall.
- Mode semantics per stage:
  - SRL: zero-fill from the MSB side.
  - SRA: fill with bit WIDTH-1 of the original operand; the sign is captured at input and carried with the op.
  - SLL: zero-fill from the LSB side.
  - ROL/ROR: bits leaving one end re-enter the other; no bit is lost.
  - Modes 5..7: data unchanged regardless of in_amt.
- Implementation latitude: left modes may be implemented by bit-reversing into a right-shift network and reversing at output. Observable results must equal the definitions above.
- Amount rules:
  - Amount 0 returns the operand unchanged in every mode.
  - The maximum amount is WIDTH-1. There is no modulo beyond SAW bits, because the port is SAW bits wide.
- out_zero is computed from the final-stage data and registered together with out_data.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both legal.
  - The pipeline advances by one stage and the new op enters stage 0.
- in_valid while in_ready=0: the op is not taken. The source must hold it; it is accepted the first cycle in_ready=1.

Test Plan:
- SLL, SRL and SRA:
  - SLL in_data=0x8000_0001, amt=1 -> 0x0000_0002 after 5 cycles.
  - SRL same operand, amt=31 -> 0x0000_0001.
  - SRA same operand, amt=4 -> 0xF800_0000.
- Rotates and pass-through:
  - ROL in_data=0x8000_0001, amt=4 -> 0x0000_0018.
  - ROR in_data=0x0000_000F, amt=4 -> 0xF000_0000.
  - Mode 6, amt=7, in_data=0x1234_5678 -> 0x1234_5678.
- Back-to-back throughput and ordering:
  - Issue 8 ops on consecutive cycles with out_ready=1 -> results on 8 consecutive cycles starting at cycle 5, in order.
  - Zero case: SRL in_data=0x0000_0001, amt=1 -> 0, out_zero=1.
- Backpressure:
  - Fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0, out_data stable, no op lost or duplicated after release.
  - Also exercise a simultaneous input/output transfer while the pipe is full.
- Reset mid-flight:
  - Assert rst_n=0 asynchronously with 3 ops in flight -> out_valid drops immediately.
  - After release, no stale result appears; the next op completes in 5 cycles.
- Parameter sweep:
  - WIDTH=8, SAW=3: ROR 0x81 amt=1 -> 0xC0 in 3 cycles.
  - Random compare against a reference model for all modes at WIDTH=8/32/64.
